// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller.
// One full-adder cell (two half adders and an OR) is reused for WIDTH cycles
// to add two WIDTH-bit operands, least significant bit first. Operands are
// captured when start is accepted. The result registers change only when a
// complete sum is available, so the display never shows a partial value.

// Half-adder cell. The full adder is built from two of these.
module serial_add_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
   // The width is kept at 1 or more so that the declaration stays legal.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nx;

   // Datapath state
   logic [WIDTH-1:0] a_sh;   // operand A, shifted right once per bit
   logic [WIDTH-1:0] b_sh;   // operand B, shifted right once per bit
   logic [WIDTH-1:0] acc;    // partial sum; new bits enter at the MSB
   logic             c_q;    // carry passed between bit slots
   logic [CW-1:0]    cnt;    // index of the bit being processed

   // Control strobes decoded from the FSM
   logic             load;   // capture operands and clear the carry
   logic             step;   // process one bit this edge
   logic             last;   // this edge processes the MSB

   // Shared full-adder cell
   logic             s0, c0, s1, c1, cnext;

   serial_add_ha u_ha0 (
      .x (a_sh[0]),
      .y (b_sh[0]),
      .s (s0),
      .c (c0)
   );

   serial_add_ha u_ha1 (
      .x (s0),
      .y (c_q),
      .s (s1),
      .c (c1)
   );

   assign cnext = c0 | c1;

   // State register. Reset aborts any add that is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, handshake outputs and datapath strobes.
   // start is looked at only in IDLE, so a request made while busy is dropped.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last     = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Operand shifters, partial-sum accumulator, carry flop and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         a_sh <= a;
         b_sh <= b;
         acc  <= '0;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else if (step) begin
         a_sh <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh <= {1'b0, b_sh[WIDTH-1:1]};
         acc  <= {s1, acc[WIDTH-1:1]};
         c_q  <= cnext;
         cnt  <= cnt + CW'(1);
      end
   end

   // Result registers. They load only on the MSB edge, so they keep the
   // previous result through IDLE and through the next RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         carry_out <= 1'b0;
      end else if (last) begin
         sum       <= {s1, acc[WIDTH-1:1]};
         carry_out <= cnext;
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. Three instances (WIDTH 8, 2 and 16) share the
// same stimulus. A timeline model computes each add with plain arithmetic and
// predicts busy, done, sum and carry_out for every cycle. Directed sequences
// check WIDTH=8 against hand-computed literals.
module tb_serial_add_ctrl;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;

   logic [7:0]  sum8;
   logic [1:0]  sum2;
   logic [15:0] sum16;
   logic        busy_o [NI];
   logic        done_o [NI];
   logic        cout_o [NI];
   logic [31:0] sum_o  [NI];

   int          ntests = 0;
   int          nfail  = 0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]),
      .busy(busy_o[0]), .done(done_o[0]), .sum(sum8), .carry_out(cout_o[0]));
   serial_add_ctrl #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a[1:0]), .b(b[1:0]),
      .busy(busy_o[1]), .done(done_o[1]), .sum(sum2), .carry_out(cout_o[1]));
   serial_add_ctrl #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a[15:0]), .b(b[15:0]),
      .busy(busy_o[2]), .done(done_o[2]), .sum(sum16), .carry_out(cout_o[2]));

   assign sum_o[0] = 32'(sum8);
   assign sum_o[1] = 32'(sum2);
   assign sum_o[2] = 32'(sum16);

   // Reference model. left is the number of cycles until the instance is
   // idle again. An accepted add takes WIDTH busy cycles and one done cycle.
   int          wd [NI] = '{8, 2, 16};
   int          left  [NI];
   int          ndone [NI];
   logic [31:0] p_sum [NI];
   logic        p_c   [NI];
   logic [31:0] m_sum [NI];
   logic        m_c   [NI];

   function automatic logic [31:0] wmask(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [32:0] wadd(input logic [31:0] x, input logic [31:0] y, input int w);
      return {1'b0, x & wmask(w)} + {1'b0, y & wmask(w)};
   endfunction

   function automatic logic [31:0] msum(input logic [31:0] x, input logic [31:0] y, input int w);
      logic [32:0] t;
      t = wadd(x, y, w);
      return t[31:0] & wmask(w);
   endfunction

   function automatic logic mcar(input logic [31:0] x, input logic [31:0] y, input int w);
      logic [32:0] t;
      t = wadd(x, y, w);
      return t[w];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            left[k]  <= 0;
            m_sum[k] <= '0;
            m_c[k]   <= 1'b0;
            p_sum[k] <= '0;
            p_c[k]   <= 1'b0;
         end else if (left[k] == 0) begin
            if (start) begin
               p_sum[k] <= msum(a, b, wd[k]);
               p_c[k]   <= mcar(a, b, wd[k]);
               left[k]  <= wd[k] + 1;
            end
         end else begin
            left[k] <= left[k] - 1;
            if (left[k] == 2) begin
               m_sum[k] <= p_sum[k];
               m_c[k]   <= p_c[k];
               ndone[k] <= ndone[k] + 1;
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < NI; k++) ndone[k] = 0;
   end

   task automatic chk(input string nm, input int w, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s (w=%0d): got %0h, want %0h at %0t", nm, w, act, exp, $time);
      end
   endtask

   // Compare every instance against the model on every cycle.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         for (int k = 0; k < NI; k++) begin
            chk("busy",  wd[k], 32'(busy_o[k]), 32'(left[k] >= 2));
            chk("done",  wd[k], 32'(done_o[k]), 32'(left[k] == 1));
            chk("sum",   wd[k], sum_o[k], m_sum[k]);
            chk("carry", wd[k], 32'(cout_o[k]), 32'(m_c[k]));
         end
      end
   end

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // One add on the WIDTH=8 instance, with latency and busy length pinned.
   task automatic run_one(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] es, input logic ec);
      int cyc, nb;
      @(negedge clk);
      start = 1'b1; a = 32'(x); b = 32'(y);
      @(negedge clk);
      start = 1'b0;
      cyc = 1; nb = 0;
      while (!done_o[0] && cyc < 40) begin
         if (busy_o[0]) nb++;
         @(negedge clk);
         cyc++;
      end
      chk("lat_done", 8, 32'(cyc), 32'd9);
      chk("busy_len", 8, 32'(nb), 32'd8);
      chk("lit_sum",  8, 32'(sum8), 32'(es));
      chk("lit_cout", 8, 32'(cout_o[0]), 32'(ec));
      idle(20);
   endtask

   initial begin
      int cnt_d, t_last, n_seen;
      int base [NI];
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 8, 32'(busy_o[0]), 32'd0);
      chk("rst_done", 8, 32'(done_o[0]), 32'd0);
      chk("rst_sum",  8, 32'(sum8), 32'd0);
      chk("rst_cout", 8, 32'(cout_o[0]), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      chk_en = 1'b1;

      run_one(8'h0F, 8'h01, 8'h10, 1'b0);
      run_one(8'hFF, 8'h01, 8'h00, 1'b1);
      run_one(8'hA5, 8'h5A, 8'hFF, 1'b0);

      // A start during RUN is dropped; the first operands are used.
      @(negedge clk); start = 1'b1; a = 32'h12; b = 32'h34;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 32'hEE; b = 32'hEE;
      @(negedge clk); start = 1'b0;
      cnt_d = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done_o[0]) cnt_d++;
      end
      chk("ign_ndone", 8, 32'(cnt_d), 32'd1);
      chk("ign_sum",   8, 32'(sum8), 32'h46);
      chk("ign_cout",  8, 32'(cout_o[0]), 32'd0);
      idle(5);

      // With start held high, adds run back to back every WIDTH+2 cycles.
      @(negedge clk); start = 1'b1; a = 32'h80; b = 32'h80;
      t_last = -1; n_seen = 0;
      for (int i = 0; i < 60 && n_seen < 3; i++) begin
         @(negedge clk);
         if (done_o[0]) begin
            if (t_last >= 0) chk("b2b_period", 8, 32'(i - t_last), 32'd10);
            chk("b2b_sum",  8, 32'(sum8), 32'h00);
            chk("b2b_cout", 8, 32'(cout_o[0]), 32'd1);
            t_last = i;
            n_seen++;
         end
      end
      chk("b2b_count", 8, 32'(n_seen), 32'd3);
      idle(20);

      // Reset in the middle of RUN.
      run_one(8'hF0, 8'h20, 8'h10, 1'b1);
      @(negedge clk); start = 1'b1; a = 32'h33; b = 32'h44;
      @(negedge clk); start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 8, 32'(busy_o[0]), 32'd0);
      chk("mid_rst_done", 8, 32'(done_o[0]), 32'd0);
      chk("mid_rst_sum",  8, 32'(sum8), 32'd0);
      chk("mid_rst_cout", 8, 32'(cout_o[0]), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      cnt_d = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_o[0]) cnt_d++;
      end
      chk("post_rst_nodone", 8, 32'(cnt_d), 32'd0);
      run_one(8'h3C, 8'h4B, 8'h87, 1'b0);

      // Random adds on all three widths.
      for (int k = 0; k < NI; k++) base[k] = ndone[k];
      for (int c = 0; c < 40000; c++) begin
         @(negedge clk);
         start = ($urandom_range(0, 9) != 0);
         a = $urandom;
         b = $urandom;
         if ((ndone[0] - base[0] >= 1000) && (ndone[1] - base[1] >= 1000) &&
             (ndone[2] - base[2] >= 1000)) break;
      end
      for (int k = 0; k < NI; k++)
         chk("rand_adds", wd[k], 32'(ndone[k] - base[k] >= 1000), 32'd1);
      idle(20);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
